ysyx_22050710_trap_ctrl: RTL
============================

Name: ysyx_22050710_trap_ctrl

Overview:
Trap sequencer sitting directly downstream of the ID-stage CSR file and upstream of the IF-stage PC mux. Accepts ecall/mret requests from decode and drives the CSR file's epu bus (ecall_sel, mret_sel, epc). Reads back mtvec/mepc, then issues a held PC-redirect to fetch under a valid/ready handshake. While a trap is in flight it back-pressures decode and flushes younger instructions.

Parameters:
DATA_WIDTH, 64, width of PC and CSR values
CNT_WIDTH, 32, width of optional trap counters

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  decode presents an instruction
o_ready  out  1  block can accept a request (state==IDLE)
i_ecall  in  1  presented instruction is ecall
i_mret  in  1  presented instruction is mret
i_pc  in  DATA_WIDTH  PC of presented instruction
o_ecall_sel  out  1  to CSR file: write mepc/mcause
o_mret_sel  out  1  to CSR file: restore mstatus
o_epc  out  DATA_WIDTH  to CSR file: faulting PC
i_mtvec  in  DATA_WIDTH  from CSR file
i_mepc  in  DATA_WIDTH  from CSR file
o_flush  out  1  kill younger in-flight instructions
o_redirect_valid  out  1  redirect request to fetch
i_redirect_ready  in  1  fetch accepts redirect
o_redirect_pc  out  DATA_WIDTH  redirect target
o_ecall_cnt  out  CNT_WIDTH  ecalls retired (optional feature only)
o_mret_cnt  out  CNT_WIDTH  mrets retired (optional feature only)

Behaviour:
- Reset (async, i_rst=1): state=IDLE; all outputs 0 except o_ready=1; internal kind/pc/target registers 0.
- States: IDLE, CSR_WR, REDIRECT.
- Accept: in IDLE, i_valid & (i_ecall | i_mret) at edge T -> latch kind and i_pc; state=CSR_WR at T+1.
- i_valid without ecall/mret: ignored, stays IDLE.
- Both i_ecall and i_mret set: ecall wins; mret ignored.
- CSR_WR (exactly 1 cycle):
  - ecall: o_ecall_sel=1, o_epc=latched pc.
  - mret: o_mret_sel=1.
  - o_flush=1 in both cases; o_epc holds latched pc only in this state, else 0.
  - On exit, capture target: ecall -> {i_mtvec[DW-1:2],2'b00}; mret -> i_mepc. Then state=REDIRECT.
- REDIRECT: o_redirect_valid=1; o_redirect_pc=captured target, stable while valid.
  - i_redirect_ready=1 -> IDLE next cycle.
  - Else hold indefinitely, no timeout.
  - Ready asserted in the first REDIRECT cycle -> total latency accept-to-IDLE = 3 edges.
- o_ready=0 in CSR_WR and REDIRECT; requests presented then are not accepted and must be held by decode.
- o_ecall_sel, o_mret_sel, o_flush are single-cycle pulses, never asserted together with each other except o_flush.
- Reset mid-operation: immediate return to IDLE; pending redirect dropped; no CSR pulse emitted after reset deasserts.

Optional Feature:
Macro YSYX_22050710_TRAP_CNT_EN.
- Defined: o_ecall_cnt / o_mret_cnt increment by 1 on each REDIRECT handshake (valid&ready) of the matching kind. They wrap modulo 2^CNT_WIDTH and reset to 0.
- Undefined: counters not built; both ports tied to 0.

Test Plan:
- Reset: assert i_rst mid-simulation asynchronously -> o_ready=1, all other outputs 0 within same cycle.
- ecall: i_pc=0x80000010, i_mtvec=0x80000101, ready tied 1 -> o_ecall_sel pulse with o_epc=0x80000010 at T+1; o_redirect_valid at T+2 with pc 0x80000100; o_ready=1 at T+3.
- mret with back-pressure: i_mepc=0x80000014, i_redirect_ready low 5 cycles -> o_mret_sel single pulse; redirect held 6 cycles at 0x80000014; o_ready stays 0 until handshake.
- Simultaneous ecall+mret with i_pc=0x80000020 -> only o_ecall_sel pulses; target from mtvec.
- Request while busy: second ecall presented during REDIRECT -> not accepted; accepted on the first IDLE cycle after handshake.
- Reset in CSR_WR: i_rst pulse -> no redirect issued; with YSYX_22050710_TRAP_CNT_EN, counters read 0; after 3 ecalls + 2 mrets, read 3/2.

Source files
------------

// File: rtl/ysyx_22050710_trap_ctrl.sv
// ysyx_22050710_trap_ctrl
//   Trap sequencer between the ID-stage CSR file and the IF-stage PC mux.
//   It takes ecall/mret from decode and pulses the CSR file's epu bus for
//   one cycle. Next it captures the trap target from mtvec or mepc. Last,
//   it holds a valid/ready PC redirect to fetch until fetch takes it.
//   Decode is back-pressured and younger instructions are flushed while a
//   trap is in flight.
//
//   Optional feature: define YSYX_22050710_TRAP_CNT_EN to build the
//   retired-ecall / retired-mret counters. When it is undefined, both
//   counter ports are tied to zero.
module ysyx_22050710_trap_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // decode request
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_ecall,
  input  logic                  i_mret,
  input  logic [DATA_WIDTH-1:0] i_pc,
  // CSR file epu bus
  output logic                  o_ecall_sel,
  output logic                  o_mret_sel,
  output logic [DATA_WIDTH-1:0] o_epc,
  input  logic [DATA_WIDTH-1:0] i_mtvec,
  input  logic [DATA_WIDTH-1:0] i_mepc,
  // pipeline control
  output logic                  o_flush,
  // redirect to fetch
  output logic                  o_redirect_valid,
  input  logic                  i_redirect_ready,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  // retired-trap counters (optional feature)
  output logic [CNT_WIDTH-1:0]  o_ecall_cnt,
  output logic [CNT_WIDTH-1:0]  o_mret_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CSR_WR   = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  typedef enum logic {
    K_MRET  = 1'b0,
    K_ECALL = 1'b1
  } kind_e;

  // Clearing the two mtvec mode bits gives the direct-mode trap base.
  localparam logic [DATA_WIDTH-1:0] MTVEC_BASE_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  state_e                state_q,  state_d;
  kind_e                 kind_q,   kind_d;
  logic [DATA_WIDTH-1:0] pc_q,     pc_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;

  logic req_trap;
  logic handshake;

  // A request is a trap only if it carries ecall or mret. Other valid
  // instructions go through untouched.
  assign req_trap  = i_valid & (i_ecall | i_mret);
  assign handshake = (state_q == S_REDIRECT) & i_redirect_ready;

  // State and transaction registers. Async reset returns to IDLE and drops any pending redirect.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      kind_q   <= K_MRET;
      pc_q     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  // Next-state, capture logic and Moore outputs decoded from the current state.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    pc_d             = pc_q;
    target_d         = target_q;

    o_ready          = 1'b0;
    o_ecall_sel      = 1'b0;
    o_mret_sel       = 1'b0;
    o_flush          = 1'b0;
    o_epc            = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;

    unique case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (req_trap) begin
          // ecall wins when both are flagged.
          kind_d  = i_ecall ? K_ECALL : K_MRET;
          pc_d    = i_pc;
          state_d = S_CSR_WR;
        end
      end

      S_CSR_WR: begin
        o_ecall_sel = (kind_q == K_ECALL);
        o_mret_sel  = (kind_q == K_MRET);
        o_flush     = 1'b1;
        o_epc       = pc_q;
        // The CSR file presents mtvec/mepc this cycle. Capture the target
        // now so the redirect address stays fixed while it is held.
        target_d    = (kind_q == K_ECALL) ? (i_mtvec & MTVEC_BASE_MASK) : i_mepc;
        state_d     = S_REDIRECT;
      end

      S_REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = target_q;
        // No timeout: the redirect stays valid until fetch accepts it.
        if (i_redirect_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef YSYX_22050710_TRAP_CNT_EN
  logic [CNT_WIDTH-1:0] ecall_cnt_q, ecall_cnt_d;
  logic [CNT_WIDTH-1:0] mret_cnt_q,  mret_cnt_d;

  // A trap counts as retired on its redirect handshake. Counters wrap freely.
  always_comb begin
    ecall_cnt_d = ecall_cnt_q;
    mret_cnt_d  = mret_cnt_q;
    if (handshake) begin
      if (kind_q == K_ECALL) begin
        ecall_cnt_d = ecall_cnt_q + 1'b1;
      end else begin
        mret_cnt_d  = mret_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ecall_cnt_q <= '0;
      mret_cnt_q  <= '0;
    end else begin
      ecall_cnt_q <= ecall_cnt_d;
      mret_cnt_q  <= mret_cnt_d;
    end
  end

  assign o_ecall_cnt = ecall_cnt_q;
  assign o_mret_cnt  = mret_cnt_q;
`else
  // Counters not built. handshake has no other consumer in this build.
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign o_ecall_cnt      = '0;
  assign o_mret_cnt       = '0;
`endif

endmodule
